wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_arbiter_if.sv | 38 +++
 rtl/wb_fifo.sv | 64 ++++++
 rtl/wb_arbiter.sv | 113 +++++++++++
 tb/tb_wb_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback arbiter slice.
package wb_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 5;
  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_FIFO_DEPTH    = 2;
  localparam int DEFAULT_STARVE_LIMIT  = 8;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [DEFAULT_ADDRESS_WIDTH-1:0] rd;
    logic [DEFAULT_DATA_WIDTH-1:0]    wd;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU result port, mul/div offer port and register-file write port.
interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH
);

  logic                          alu_valid;
  logic [ADDRESS_WIDTH-1:0]      alu_rd;
  logic [DATA_WIDTH-1:0]         alu_wd;
  logic                          alu_stall;

  logic                          md_valid;
  logic                          md_ready;
  logic [ADDRESS_WIDTH-1:0]      md_rd;
  logic [DATA_WIDTH-1:0]         md_wd;

  logic                          WE3;
  logic [ADDRESS_WIDTH-1:0]      AD3;
  logic [DATA_WIDTH-1:0]         WD3;

  logic [$clog2(FIFO_DEPTH):0]   md_count;

  // Producer / register-file side.
  modport master (
    output alu_valid, alu_rd, alu_wd, md_valid, md_rd, md_wd,
    input  alu_stall, md_ready, WE3, AD3, WD3, md_count
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_wd, md_valid, md_rd, md_wd,
    output alu_stall, md_ready, WE3, AD3, WD3, md_count
  );

endinterface

// File: rtl/wb_fifo.sv
// Small FIFO of pending mul/div writebacks; depth must be a power of two so
// the pointers wrap naturally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wb_req_t                  push_data,
  input  logic                     pop,
  output wb_req_t                  pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t         mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Pointer and occupancy update; push and pop together leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every buffered entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU results win by default, mul/div results
// wait in a small FIFO and drain when the ALU port is free.
// Optional WB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive ALU wins over a
// non-empty buffer, the ALU is stalled for one cycle so the head can drain.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
  parameter int STARVE_LIMIT  = DEFAULT_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_arbiter_if.slave   bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_req_t                 push_data;
  wb_req_t                 head;
  logic                    push, pop, full, empty;
  logic [CW-1:0]           count;
  logic                    alu_stall, alu_win, md_ready;

  logic                    we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] ad_q, ad_d;
  logic [DATA_WIDTH-1:0]    wd_q, wd_d;

  // md_ready comes from registered occupancy only, so a full buffer never
  // accepts even when it pops in the same cycle.
  assign md_ready     = !full;
  assign alu_win      = bus.alu_valid && !alu_stall && (bus.alu_rd != '0);
  assign pop          = !alu_win && !empty;
  assign push         = bus.md_valid && md_ready && (bus.md_rd != '0);
  assign push_data.rd = bus.md_rd;
  assign push_data.wd = bus.md_wd;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;

  assign alu_stall = !empty && (starve_q == SW'(STARVE_LIMIT));

  // Count ALU wins that block a waiting entry; any pop or an empty buffer clears it.
  always_comb begin
    starve_d = starve_q;
    if (pop || empty)  starve_d = '0;
    else if (alu_win)  starve_d = starve_q + 1'b1;
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  logic unused_starve_limit;

  assign alu_stall           = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  // Pick this cycle's write; address/data hold when nothing is written.
  always_comb begin
    we_d = 1'b0;
    ad_d = ad_q;
    wd_d = wd_q;
    if (alu_win) begin
      we_d = 1'b1;
      ad_d = bus.alu_rd;
      wd_d = bus.alu_wd;
    end else if (pop) begin
      we_d = 1'b1;
      ad_d = head.rd;
      wd_d = head.wd;
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      ad_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= we_d;
      ad_q <= ad_d;
      wd_q <= wd_d;
    end
  end

  assign bus.WE3       = we_q;
  assign bus.AD3       = ad_q;
  assign bus.WD3       = wd_q;
  assign bus.alu_stall = alu_stall;
  assign bus.md_ready  = md_ready;
  assign bus.md_count  = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default depth 2, limit 8).
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drive both producer ports for the coming cycle.
  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] aw,
                               input logic mv, input logic [4:0] mr, input logic [31:0] mw);
    bus.alu_valid = av;
    bus.alu_rd    = ar;
    bus.alu_wd    = aw;
    bus.md_valid  = mv;
    bus.md_rd     = mr;
    bus.md_wd     = mw;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the write port in one go.
  task automatic checkWrite(input string tag, input logic we, input logic [4:0] ad,
                            input logic [31:0] wd);
    checkOutput({tag, ".WE3"}, 64'(bus.WE3), 64'(we));
    checkOutput({tag, ".AD3"}, 64'(bus.AD3), 64'(ad));
    checkOutput({tag, ".WD3"}, 64'(bus.WD3), 64'(wd));
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    checkWrite("reset", 0, 0, 0);
    checkOutput("reset.count", 64'(bus.md_count), 0);
    checkOutput("reset.ready", 64'(bus.md_ready), 1);
    checkOutput("reset.stall", 64'(bus.alu_stall), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    checkWrite("idle", 0, 0, 0);

    // Single mul/div result, ALU idle: written two edges after acceptance.
    applyStimulus(0, 0, 0, 1, 5, 32'hDEADBEEF);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("md1.we_early", 64'(bus.WE3), 0);
    checkOutput("md1.count", 64'(bus.md_count), 1);
    step();
    checkWrite("md1.write", 1, 5, 32'hDEADBEEF);
    checkOutput("md1.count_after", 64'(bus.md_count), 0);
    step();
    checkWrite("md1.hold", 0, 5, 32'hDEADBEEF);

    // ALU beats a buffered entry, entry follows next cycle.
    applyStimulus(0, 0, 0, 1, 4, 32'h22);
    step();
    applyStimulus(1, 3, 32'h11, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkWrite("prio.alu", 1, 3, 32'h11);
    checkOutput("prio.count", 64'(bus.md_count), 1);
    step();
    checkWrite("prio.md", 1, 4, 32'h22);
    step();
    checkOutput("prio.done", 64'(bus.WE3), 0);

    // Fill the buffer under continuous ALU traffic, third offer held off.
    applyStimulus(1, 1, 32'hA0, 1, 10, 32'h100);
    step();
    checkWrite("fill.alu1", 1, 1, 32'hA0);
    checkOutput("fill.ready1", 64'(bus.md_ready), 1);
    applyStimulus(1, 1, 32'hA0, 1, 11, 32'h101);
    step();
    checkOutput("fill.count2", 64'(bus.md_count), 2);
    checkOutput("fill.ready0", 64'(bus.md_ready), 0);
    applyStimulus(1, 1, 32'hA0, 1, 12, 32'h102);
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput("fill.held_count", 64'(bus.md_count), 2);
      checkOutput("fill.held_ready", 64'(bus.md_ready), 0);
      checkOutput("fill.stall", 64'(bus.alu_stall), 0);
      checkWrite("fill.alu", 1, 1, 32'hA0);
    end
    applyStimulus(0, 0, 0, 1, 12, 32'h102);
    step();
    checkWrite("drain.first", 1, 10, 32'h100);
    checkOutput("drain.count1", 64'(bus.md_count), 1);
    checkOutput("drain.ready1", 64'(bus.md_ready), 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkWrite("drain.second", 1, 11, 32'h101);
    checkOutput("drain.pushpop", 64'(bus.md_count), 1);
    step();
    checkWrite("drain.third", 1, 12, 32'h102);
    checkOutput("drain.empty", 64'(bus.md_count), 0);
    step();
    checkOutput("drain.done", 64'(bus.WE3), 0);

    // ALU rd=0 is dropped and lets the buffered entry through; md rd=0 not stored.
    applyStimulus(0, 0, 0, 1, 7, 32'h77);
    step();
    applyStimulus(1, 0, 32'h55, 1, 0, 32'h99);
    checkOutput("zero.ready", 64'(bus.md_ready), 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkWrite("zero.md7", 1, 7, 32'h77);
    checkOutput("zero.count", 64'(bus.md_count), 0);
    step();
    checkWrite("zero.nowrite", 0, 7, 32'h77);
    checkOutput("zero.count2", 64'(bus.md_count), 0);

    // Long ALU stream against one buffered entry.
    applyStimulus(1, 2, 32'h22, 1, 9, 32'h99);
    step();
    applyStimulus(1, 2, 32'h22, 0, 0, 0);
    checkOutput("starve.stall0", 64'(bus.alu_stall), 0);
`ifdef WB_STARVE_GUARD_EN
    for (int i = 1; i <= 8; i++) begin
      step();
      checkOutput("starve.stall", 64'(bus.alu_stall), (i == 8) ? 64'd1 : 64'd0);
      checkWrite("starve.alu", 1, 2, 32'h22);
    end
    step();
    checkWrite("starve.md", 1, 9, 32'h99);
    checkOutput("starve.count", 64'(bus.md_count), 0);
    checkOutput("starve.stall_clr", 64'(bus.alu_stall), 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkWrite("starve.alu_after", 1, 2, 32'h22);
`else
    for (int i = 1; i <= 9; i++) begin
      step();
      checkOutput("nostarve.stall", 64'(bus.alu_stall), 0);
      checkOutput("nostarve.count", 64'(bus.md_count), 1);
      checkWrite("nostarve.alu", 1, 2, 32'h22);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    checkWrite("nostarve.md", 1, 9, 32'h99);
`endif
    step();
    checkOutput("starve.done", 64'(bus.WE3), 0);

    // Reset with a full buffer: everything clears at once and nothing drains later.
    applyStimulus(1, 1, 32'hB0, 1, 13, 32'h13);
    step();
    applyStimulus(1, 1, 32'hB0, 1, 14, 32'h14);
    step();
    checkOutput("rst.count_before", 64'(bus.md_count), 2);
    #2 rst_n = 1'b0;
    #1;
    checkWrite("rst.async", 0, 0, 0);
    checkOutput("rst.count", 64'(bus.md_count), 0);
    checkOutput("rst.ready", 64'(bus.md_ready), 1);
    checkOutput("rst.stall", 64'(bus.alu_stall), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rst.no_we", 64'(bus.WE3), 0);
      checkOutput("rst.empty", 64'(bus.md_count), 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
